// File: rtl/scm_bist_pkg.sv
// Shared types and the March C- element table for the SCM BIST controller.
package scm_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

  localparam int NUM_MARCH_ELEM = 6;

  // One March element: walk direction, optional read (with expected
  // background) followed by an optional write (with new background).
  typedef struct packed {
    logic dir_down;
    logic has_read;
    logic read_val;
    logic has_write;
    logic write_val;
  } march_elem_t;

  // Index 0 is the rightmost entry, so the list reads E5 down to E0.
  localparam march_elem_t [NUM_MARCH_ELEM-1:0] MARCH_C_MINUS = {
    march_elem_t'{dir_down: 1'b0, has_read: 1'b1, read_val: 1'b0, has_write: 1'b0, write_val: 1'b0}, // E5 up   (r0)
    march_elem_t'{dir_down: 1'b1, has_read: 1'b1, read_val: 1'b1, has_write: 1'b1, write_val: 1'b0}, // E4 down (r1,w0)
    march_elem_t'{dir_down: 1'b1, has_read: 1'b1, read_val: 1'b0, has_write: 1'b1, write_val: 1'b1}, // E3 down (r0,w1)
    march_elem_t'{dir_down: 1'b0, has_read: 1'b1, read_val: 1'b1, has_write: 1'b1, write_val: 1'b0}, // E2 up   (r1,w0)
    march_elem_t'{dir_down: 1'b0, has_read: 1'b1, read_val: 1'b0, has_write: 1'b1, write_val: 1'b1}, // E1 up   (r0,w1)
    march_elem_t'{dir_down: 1'b0, has_read: 1'b0, read_val: 1'b0, has_write: 1'b1, write_val: 1'b0}  // E0 up   (w0)
  };

endpackage

// File: rtl/scm_bist_addr_gen.sv
// Up/down address counter for the March walk, with load-to-0 / load-to-max
// and a terminal-address flag for the current walk direction.
module scm_bist_addr_gen #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  load_down,
  input  logic                  step,
  input  logic                  dir_down,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last_o
);

  // Load takes priority over stepping; a load starts a new element walk.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_down ? '1 : '0;
    end else if (step) begin
      addr <= dir_down ? addr - 1'b1 : addr + 1'b1;
    end
  end

  assign last_o = dir_down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/scm_bist_march_ctrl.sv
// March C- BIST initiator for one latch-based SCM macro.
// Build option: define SCM_BIST_DIAG_EN to capture the first-failure
// address, element and read data; otherwise those outputs are tied to 0.
module scm_bist_march_ctrl
  import scm_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic                  BIST,
  output logic                  CSN_T,
  output logic                  WEN_T,
  output logic [ADDR_WIDTH-1:0] A_T,
  output logic [DATA_WIDTH-1:0] D_T,
  output logic [NUM_BYTE-1:0]   BE_T,
  input  logic [DATA_WIDTH-1:0] Q_T,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [2:0]            fail_elem_o,
  output logic [DATA_WIDTH-1:0] fail_data_o,
  output logic [1:0]            state_o
);

  bist_state_t           state_q, state_d;
  logic [2:0]            elem_q, elem_nxt;
  logic                  phase_q;     // 0: read slot, 1: write slot of a two-op element
  logic [ADDR_WIDTH-1:0] addr;
  logic                  addr_last;
  march_elem_t           cur, nxt;
  logic                  is_run, op_read, op_last, elem_end, run_end, start_ok;
  logic                  cmp_vld;
  logic [DATA_WIDTH-1:0] cmp_exp;
  logic                  mismatch;

  assign elem_nxt = (elem_q == 3'(NUM_MARCH_ELEM - 1)) ? 3'd0 : elem_q + 3'd1;
  assign cur      = MARCH_C_MINUS[elem_q];
  assign nxt      = MARCH_C_MINUS[elem_nxt];

  assign is_run   = (state_q == RUN);
  assign start_ok = start_i && ((state_q == IDLE) || (state_q == DONE));
  assign op_read  = cur.has_read && !phase_q;
  // The address is finished unless we just read and a write still follows.
  assign op_last  = !(op_read && cur.has_write);
  assign elem_end = is_run && op_last && addr_last;
  assign run_end  = elem_end && (elem_q == 3'(NUM_MARCH_ELEM - 1));

  scm_bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (start_ok || (elem_end && !run_end)),
    .load_down (start_ok ? MARCH_C_MINUS[0].dir_down : nxt.dir_down),
    .step      (is_run && op_last && !addr_last),
    .dir_down  (cur.dir_down),
    .addr      (addr),
    .last_o    (addr_last)
  );

  // Next-state logic: RUN until the final E5 read, one DRAIN cycle for the
  // last pipelined compare, then DONE until restarted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (run_end)  state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (start_ok) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // State, element/phase sequencing, read-compare pipeline and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      elem_q  <= '0;
      phase_q <= 1'b0;
      cmp_vld <= 1'b0;
      cmp_exp <= '0;
      done_o  <= 1'b0;
      fail_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmp_vld <= is_run && op_read;
      cmp_exp <= {DATA_WIDTH{cur.read_val}};
      if (start_ok) begin
        elem_q  <= '0;
        phase_q <= 1'b0;
        done_o  <= 1'b0;
        fail_o  <= 1'b0;
      end else begin
        if (is_run) begin
          phase_q <= !op_last;
          if (elem_end && !run_end) elem_q <= elem_nxt;
        end
        if (state_q == DRAIN) done_o <= 1'b1;
        if (mismatch) fail_o <= 1'b1;
      end
    end
  end

  assign mismatch = cmp_vld && (Q_T != cmp_exp);

`ifdef SCM_BIST_DIAG_EN
  logic [ADDR_WIDTH-1:0] cmp_addr, fail_addr_q;
  logic [2:0]            cmp_elem, fail_elem_q;
  logic [DATA_WIDTH-1:0] fail_data_q;

  // Remember where each read was issued; latch it on the first mismatch only.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_addr    <= '0;
      cmp_elem    <= '0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_data_q <= '0;
    end else begin
      cmp_addr <= addr;
      cmp_elem <= elem_q;
      if (start_ok) begin
        fail_addr_q <= '0;
        fail_elem_q <= '0;
        fail_data_q <= '0;
      end else if (mismatch && !fail_o) begin
        fail_addr_q <= cmp_addr;
        fail_elem_q <= cmp_elem;
        fail_data_q <= Q_T;
      end
    end
  end

  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;
  assign fail_data_o = fail_data_q;
`else
  assign fail_addr_o = '0;
  assign fail_elem_o = '0;
  assign fail_data_o = '0;
`endif

  // Test port group: one operation per RUN cycle, idle values elsewhere.
  assign busy_o  = (state_q == RUN) || (state_q == DRAIN);
  assign BIST    = busy_o;
  assign CSN_T   = !is_run;
  assign WEN_T   = !(is_run && !op_read);
  assign A_T     = is_run ? addr : '0;
  assign D_T     = (is_run && !op_read) ? {DATA_WIDTH{cur.write_val}} : '0;
  assign BE_T    = '1;
  assign state_o = state_q;

endmodule

// File: tb/tb_scm_bist_march_ctrl.sv
// Self-checking bench for scm_bist_march_ctrl with a behavioural SCM that
// can inject a stuck-at-1 cell or an address-decoder alias.
module tb_scm_bist_march_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NW = 1 << AW;
  localparam int OPW = 1 + AW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          busy_o, done_o, fail_o, BIST, CSN_T, WEN_T;
  logic [AW-1:0] A_T, fail_addr_o;
  logic [DW-1:0] D_T, Q_T, fail_data_o;
  logic [3:0]    BE_T;
  logic [2:0]    fail_elem_o;
  logic [1:0]    state_o;

  logic [OPW-1:0] exp_q[$];
  logic [DW-1:0]  mem [NW];
  int             fault_mode = 0;
  int             op_cnt = 0;
  int             n_vec = 0;
  int             n_err = 0;

  scm_bist_march_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .fail_o      (fail_o),
    .BIST        (BIST),
    .CSN_T       (CSN_T),
    .WEN_T       (WEN_T),
    .A_T         (A_T),
    .D_T         (D_T),
    .BE_T        (BE_T),
    .Q_T         (Q_T),
    .fail_addr_o (fail_addr_o),
    .fail_elem_o (fail_elem_o),
    .fail_data_o (fail_data_o),
    .state_o     (state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Behavioural SCM: read data appears one cycle after the request.
  initial begin
    Q_T = '0;
    for (int i = 0; i < NW; i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    if (!CSN_T) begin
      if (!WEN_T) begin
        mem[A_T] <= (fault_mode == 1 && A_T == 5'd7) ? (D_T | 32'h8) : D_T;
        if (fault_mode == 2 && A_T == 5'd4) mem[5] <= D_T;
      end else begin
        Q_T <= mem[A_T];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected March C- op stream: {wen, addr, data}; data is zero for reads.
  task automatic push_ops();
    bit          down [6] = '{0, 0, 0, 1, 1, 0};
    bit          rd   [6] = '{0, 1, 1, 1, 1, 1};
    bit          wr   [6] = '{1, 1, 1, 1, 1, 0};
    bit          wv   [6] = '{0, 1, 0, 1, 0, 0};
    logic [AW-1:0] a;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < NW; k++) begin
        a = down[e] ? AW'(NW - 1 - k) : AW'(k);
        if (rd[e]) exp_q.push_back({1'b1, a, {DW{1'b0}}});
        if (wr[e]) exp_q.push_back({1'b0, a, {DW{wv[e]}}});
      end
    end
  endtask

  // Monitor: every active test-port cycle is popped against the model.
  always begin
    logic [OPW-1:0] obs;
    @(posedge clk);
    #1;
    if (!CSN_T) begin
      op_cnt++;
      obs = WEN_T ? {1'b1, A_T, {DW{1'b0}}} : {1'b0, A_T, D_T};
      if (exp_q.size() == 0) check("op_unexpected", {63'b0, !CSN_T}, 64'd0);
      else check("op_seq", {26'b0, obs}, {26'b0, exp_q.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_march(input int fault, input int rst_at, input int restart_at,
                           input logic exp_fail, input logic [AW-1:0] exp_faddr,
                           input logic [2:0] exp_felem, input logic [DW-1:0] exp_fdata);
    int n;
    fault_mode = fault;
    repeat ($urandom_range(1, 5)) step();
    push_ops();
    op_cnt  = 0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    n = 1;
    while (!done_o && n < 400) begin
      start_i = (n == restart_at);
      if (n == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_bist", {63'b0, BIST}, 64'd0);
        check("rst_csn", {63'b0, CSN_T}, 64'd1);
        check("rst_busy", {63'b0, busy_o}, 64'd0);
        check("rst_done", {63'b0, done_o}, 64'd0);
        check("rst_fail", {63'b0, fail_o}, 64'd0);
        exp_q.delete();
        return;
      end
      step();
      n++;
    end
    start_i = 1'b0;
    check("done_cycle", 64'(n), 64'd322);
    check("op_count", 64'(op_cnt), 64'd320);
    check("queue_left", 64'(exp_q.size()), 64'd0);
    check("fail", {63'b0, fail_o}, {63'b0, exp_fail});
    check("bist_after", {63'b0, BIST}, 64'd0);
    check("busy_after", {63'b0, busy_o}, 64'd0);
    check("be_all_ones", {60'b0, BE_T}, 64'hF);
`ifdef SCM_BIST_DIAG_EN
    check("fail_addr", {59'b0, fail_addr_o}, {59'b0, exp_faddr});
    check("fail_elem", {61'b0, fail_elem_o}, {61'b0, exp_felem});
    check("fail_data", {32'b0, fail_data_o}, {32'b0, exp_fdata});
`else
    check("fail_addr", {59'b0, fail_addr_o}, 64'd0);
    check("fail_elem", {61'b0, fail_elem_o}, 64'd0);
    check("fail_data", {32'b0, fail_data_o}, 64'd0);
`endif
    repeat (3) step();
    check("done_hold", {63'b0, done_o}, 64'd1);
    check("fail_hold", {63'b0, fail_o}, {63'b0, exp_fail});
    exp_q.delete();
  endtask

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("reset_busy", {63'b0, busy_o}, 64'd0);
    check("reset_done", {63'b0, done_o}, 64'd0);
    check("reset_fail", {63'b0, fail_o}, 64'd0);
    check("reset_bist", {63'b0, BIST}, 64'd0);
    check("reset_csn", {63'b0, CSN_T}, 64'd1);
    check("reset_wen", {63'b0, WEN_T}, 64'd1);
    check("reset_a", {59'b0, A_T}, 64'd0);
    check("reset_d", {32'b0, D_T}, 64'd0);
    check("reset_be", {60'b0, BE_T}, 64'hF);
    check("reset_faddr", {59'b0, fail_addr_o}, 64'd0);
    check("reset_felem", {61'b0, fail_elem_o}, 64'd0);
    check("reset_fdata", {32'b0, fail_data_o}, 64'd0);

    // Fault-free run
    run_march(0, 0, 0, 1'b0, 5'd0, 3'd0, 32'h0);
    // Stuck-at-1 on bit 3 of address 7
    run_march(1, 0, 0, 1'b1, 5'd7, 3'd1, 32'h0000_0008);
    // Write to address 4 also lands in address 5
    run_march(2, 0, 0, 1'b1, 5'd5, 3'd1, 32'hFFFF_FFFF);
    // Reset in the middle of a run, then a clean run
    run_march(0, 100, 0, 1'b0, 5'd0, 3'd0, 32'h0);
    run_march(0, 0, 0, 1'b0, 5'd0, 3'd0, 32'h0);
    // A second start while running is ignored
    run_march(0, 0, 50, 1'b0, 5'd0, 3'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
